out_port_buffer: RTL

//   Output-port FIFO directly downstream of the processor core's OUT path.

---
 rtl/out_port_buffer.sv | 54 +++++
 1 files changed

// File: rtl/out_port_buffer.sv
// out_port_buffer: show-ahead output-port FIFO with sticky overflow between core OUT path and a listener
module out_port_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              overflow_clr
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              push, pop, drop;

  // status and handshake derived purely from registered state
  always_comb begin
    empty     = level == '0;
    full      = level == (ADDR_W+1)'(DEPTH);
    out_valid = ~empty;
    out_data  = empty ? '0 : mem[rd_ptr];
    pop       = out_valid & out_ready;
    push      = in_en & (~full | pop);
    drop      = in_en & full & ~pop;
  end

  // storage array carries no reset; only pointers/level qualify its contents
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;

  // pointers, occupancy and sticky overflow; a drop beats a concurrent clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop) level <= level + 1'b1;
      else if (pop & ~push) level <= level - 1'b1;
      if (drop) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
endmodule
